// File: rtl/ps2_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_event_ctrl
//
// Sits between the PS/2 byte receiver and a registered scan-code lookup
// table. Decodes F0 (break) and E0 (extended) prefixes, tracks Shift, Ctrl,
// Alt and Caps Lock, addresses the lookup table, applies letter case to the
// returned ASCII and queues characters in a show-ahead FIFO.
//
// Ports
//   clk          system clock, all logic on posedge
//   clrn         synchronous active-low reset
//   code_valid   raw scan byte present
//   code         raw scan byte
//   code_ready   controller can take a byte (IDLE / BRK / EXT / EXT_BRK)
//   lut_scan     registered address to the lookup table
//   lut_ascii    lookup data, valid one clk after lut_scan changes
//   key_valid    FIFO non-empty
//   key_ascii    head-of-FIFO character
//   key_ready    consumer pops the head when key_valid & key_ready
//   fifo_level   number of queued characters
//   press_count  characters queued since reset (wraps)
//   shift_held, ctrl_held, alt_held, caps_on   modifier status
//   overflow     sticky, a character was dropped on a full FIFO
//
// State table
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_IDLE    | waiting for a make byte or a prefix
//   S_BRK     | F0 seen, next byte is the released key
//   S_EXT     | E0 seen, next byte is an extended make (or F0)
//   S_EXT_BRK | E0 F0 seen, next byte is an extended release
//   S_LOOKUP  | lut_scan presented, table registering its data
//   S_CAPTURE | lut_ascii valid, case applied and character pushed
// ---------------------------------------------------------------------------
module ps2_key_event_ctrl #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          clrn,
   input  logic                          code_valid,
   input  logic [7:0]                    code,
   output logic                          code_ready,
   output logic [7:0]                    lut_scan,
   input  logic [7:0]                    lut_ascii,
   output logic                          key_valid,
   output logic [7:0]                    key_ascii,
   input  logic                          key_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    press_count,
   output logic                          shift_held,
   output logic                          ctrl_held,
   output logic                          alt_held,
   output logic                          caps_on,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BRK,
      S_EXT,
      S_EXT_BRK,
      S_LOOKUP,
      S_CAPTURE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic       accept;
   logic       is_modifier;
   logic       push_req;
   logic [7:0] push_data;
   logic       caps_held;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push_ok;

   assign accept = code_valid & code_ready;

   assign is_modifier = (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
                        (code == SC_CTRL)   || (code == SC_ALT)    ||
                        (code == SC_CAPS);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (code == SC_BREAK) begin
                  state_nxt = S_BRK;
               end else if (code == SC_EXT) begin
                  state_nxt = S_EXT;
               end else if (!is_modifier) begin
                  state_nxt = S_LOOKUP;
               end
            end
         end
         S_BRK: begin
            if (accept) state_nxt = S_IDLE;
         end
         S_EXT: begin
            if (accept) state_nxt = (code == SC_BREAK) ? S_EXT_BRK : S_IDLE;
         end
         S_EXT_BRK: begin
            if (accept) state_nxt = S_IDLE;
         end
         S_LOOKUP:  state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Letters come out of the table in upper case; they stay upper only when
   // exactly one of Shift / Caps Lock is active.
   always_comb begin
      code_ready = 1'b0;
      push_req   = 1'b0;
      push_data  = lut_ascii;
      case (state)
         S_IDLE, S_BRK, S_EXT, S_EXT_BRK: code_ready = 1'b1;
         S_CAPTURE: begin
            push_req = (lut_ascii != 8'd0);
            if ((lut_ascii >= 8'd65) && (lut_ascii <= 8'd90) &&
                !(shift_held ^ caps_on)) begin
               push_data = lut_ascii + 8'd32;
            end
         end
         default: ;
      endcase
   end

   // ---------------- modifier flags and table address ----------------
   // caps_held suppresses re-toggling while the Caps key auto-repeats.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         shift_held <= 1'b0;
         ctrl_held  <= 1'b0;
         alt_held   <= 1'b0;
         caps_on    <= 1'b0;
         caps_held  <= 1'b0;
         lut_scan   <= 8'd0;
      end else if (accept) begin
         case (state)
            S_IDLE: begin
               case (code)
                  SC_LSHIFT, SC_RSHIFT: shift_held <= 1'b1;
                  SC_CTRL:              ctrl_held  <= 1'b1;
                  SC_ALT:               alt_held   <= 1'b1;
                  SC_CAPS: begin
                     if (!caps_held) caps_on <= ~caps_on;
                     caps_held <= 1'b1;
                  end
                  SC_BREAK, SC_EXT: ;
                  default:              lut_scan <= code;
               endcase
            end
            S_BRK: begin
               case (code)
                  SC_LSHIFT, SC_RSHIFT: shift_held <= 1'b0;
                  SC_CTRL:              ctrl_held  <= 1'b0;
                  SC_ALT:               alt_held   <= 1'b0;
                  SC_CAPS:              caps_held  <= 1'b0;
                  default: ;
               endcase
            end
            S_EXT: begin
               case (code)
                  SC_CTRL: ctrl_held <= 1'b1;
                  SC_ALT:  alt_held  <= 1'b1;
                  default: ;
               endcase
            end
            S_EXT_BRK: begin
               case (code)
                  SC_CTRL: ctrl_held <= 1'b0;
                  SC_ALT:  alt_held  <= 1'b0;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // ---------------- character FIFO ----------------
   // A push into a full FIFO still succeeds when the head is popped on the
   // same edge.
   assign full    = (level == LW'(FIFO_DEPTH));
   assign empty   = (level == '0);
   assign pop     = key_ready & ~empty;
   assign push_ok = push_req & (~full | pop);

   always_ff @(posedge clk) begin
      if (!clrn) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         overflow    <= 1'b0;
         press_count <= 8'd0;
      end else begin
         if (push_ok) begin
            wr_ptr      <= wr_ptr + AW'(1);
            press_count <= press_count + 8'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (push_req && !push_ok) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign key_valid  = ~empty;
   assign key_ascii  = mem[rd_ptr];
   assign fifo_level = level;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       code_valid = 1'b0;
   logic [7:0] code = 8'd0;
   logic       code_ready;
   logic [7:0] lut_scan;
   logic [7:0] lut_ascii = 8'd0;
   logic       key_valid;
   logic [7:0] key_ascii;
   logic       key_ready = 1'b0;
   logic [3:0] fifo_level;
   logic [7:0] press_count;
   logic       shift_held, ctrl_held, alt_held, caps_on, overflow;

   int vectors = 0;
   int miscompares = 0;

   ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .clrn(clrn), .code_valid(code_valid), .code(code),
      .code_ready(code_ready), .lut_scan(lut_scan), .lut_ascii(lut_ascii),
      .key_valid(key_valid), .key_ascii(key_ascii), .key_ready(key_ready),
      .fifo_level(fifo_level), .press_count(press_count),
      .shift_held(shift_held), .ctrl_held(ctrl_held), .alt_held(alt_held),
      .caps_on(caps_on), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // External registered scan-code table: upper-case letters, space, 0 = unmapped.
   function automatic logic [7:0] table_fn(input logic [7:0] s);
      case (s)
         8'h1C:   return 8'h41;
         8'h32:   return 8'h42;
         8'h21:   return 8'h43;
         8'h29:   return 8'h20;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) lut_ascii <= table_fn(lut_scan);

   task automatic do_reset();
      clrn = 1'b0; code_valid = 1'b0; key_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!code_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!code_ready) begin
         vectors++; miscompares++;
         $display("FAIL wait_ready: code_ready=%0b after %0d cycles, required 1", code_ready, n);
      end
   endtask

   // Presents one byte; returns at the negedge after the accept edge.
   task automatic send_byte(input logic [7:0] b);
      wait_ready();
      code_valid = 1'b1; code = b;
      @(negedge clk);
      code_valid = 1'b0;
   endtask

   task automatic pop_one();
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] st;
      do_reset();
      st = {code_ready, key_valid, shift_held, ctrl_held, alt_held, caps_on, overflow};
      vectors++;
      if (st !== 7'b1000000) begin miscompares++; $display("FAIL reset_flags: got %b required 1000000", st); end
      vectors++;
      if (lut_scan !== 8'd0) begin miscompares++; $display("FAIL reset_lut_scan: got %h required 00", lut_scan); end
      vectors++;
      if (fifo_level !== 4'd0 || press_count !== 8'd0) begin miscompares++;
         $display("FAIL reset_counts: level=%0d press=%0d required 0 0", fifo_level, press_count); end
   endtask

   task automatic test_basic();
      do_reset();
      send_byte(8'h1C);
      vectors++;
      if (code_ready !== 1'b0 || lut_scan !== 8'h1C) begin miscompares++;
         $display("FAIL basic_lookup: code_ready=%0b lut_scan=%h required 0 1c", code_ready, lut_scan); end
      @(negedge clk);
      vectors++;
      if (key_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early: key_valid=%0b required 0", key_valid); end
      @(negedge clk);
      vectors++;
      if (key_valid !== 1'b1 || key_ascii !== 8'h61 || press_count !== 8'd1 || fifo_level !== 4'd1) begin
         miscompares++;
         $display("FAIL basic_push: valid=%0b ascii=%h press=%0d level=%0d required 1 61 1 1",
                  key_valid, key_ascii, press_count, fifo_level);
      end
      pop_one();
      vectors++;
      if (key_valid !== 1'b0 || fifo_level !== 4'd0) begin miscompares++;
         $display("FAIL basic_pop: valid=%0b level=%0d required 0 0", key_valid, fifo_level); end
   endtask

   task automatic test_shift();
      do_reset();
      send_byte(8'h12);
      vectors++;
      if (shift_held !== 1'b1) begin miscompares++; $display("FAIL shift_set: got %0b required 1", shift_held); end
      send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h12);
      vectors++;
      if (shift_held !== 1'b0) begin miscompares++; $display("FAIL shift_clear: got %0b required 0", shift_held); end
      send_byte(8'h1C);
      wait_ready();
      vectors++;
      if (fifo_level !== 4'd2 || key_ascii !== 8'h41) begin miscompares++;
         $display("FAIL shift_head: level=%0d ascii=%h required 2 41", fifo_level, key_ascii); end
      pop_one();
      vectors++;
      if (key_ascii !== 8'h61 || fifo_level !== 4'd1) begin miscompares++;
         $display("FAIL shift_second: ascii=%h level=%0d required 61 1", key_ascii, fifo_level); end
   endtask

   task automatic test_caps();
      logic [7:0] seq [8] = '{8'h58, 8'hF0, 8'h58, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h32};
      logic       exp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send_byte(seq[i]);
         vectors++;
         if (caps_on !== exp[i]) begin miscompares++;
            $display("FAIL caps_step%0d: caps_on=%0b required %0b", i, caps_on, exp[i]); end
      end
      wait_ready();
      vectors++;
      if (fifo_level !== 4'd1 || key_ascii !== 8'h62) begin miscompares++;
         $display("FAIL caps_char: level=%0d ascii=%h required 1 62", fifo_level, key_ascii); end
      // Caps alone gives upper case; Caps plus Shift gives lower case.
      send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
      send_byte(8'h21);
      send_byte(8'h59); send_byte(8'h21);
      wait_ready();
      pop_one();
      vectors++;
      if (key_ascii !== 8'h43) begin miscompares++; $display("FAIL caps_upper: ascii=%h required 43", key_ascii); end
      pop_one();
      vectors++;
      if (key_ascii !== 8'h63) begin miscompares++; $display("FAIL caps_shift: ascii=%h required 63", key_ascii); end
   endtask

   task automatic test_extended();
      do_reset();
      send_byte(8'hE0); send_byte(8'h14);
      vectors++;
      if (ctrl_held !== 1'b1 || fifo_level !== 4'd0) begin miscompares++;
         $display("FAIL ext_ctrl_set: ctrl=%0b level=%0d required 1 0", ctrl_held, fifo_level); end
      send_byte(8'h11);
      vectors++;
      if (alt_held !== 1'b1) begin miscompares++; $display("FAIL alt_set: alt=%0b required 1", alt_held); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
      vectors++;
      if (ctrl_held !== 1'b0 || alt_held !== 1'b1) begin miscompares++;
         $display("FAIL ext_ctrl_clear: ctrl=%0b alt=%0b required 0 1", ctrl_held, alt_held); end
      send_byte(8'h77);
      wait_ready();
      @(negedge clk);
      vectors++;
      if (fifo_level !== 4'd0 || press_count !== 8'd0 || key_valid !== 1'b0) begin miscompares++;
         $display("FAIL unmapped: level=%0d press=%0d valid=%0b required 0 0 0", fifo_level, press_count, key_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i <= DEPTH; i++) send_byte(8'h29);
      wait_ready();
      vectors++;
      if (fifo_level !== 4'(DEPTH) || overflow !== 1'b1 || press_count !== 8'(DEPTH)) begin miscompares++;
         $display("FAIL overflow: level=%0d ovf=%0b press=%0d required %0d 1 %0d",
                  fifo_level, overflow, press_count, DEPTH, DEPTH); end
      send_byte(8'h29);
      @(negedge clk);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      vectors++;
      if (fifo_level !== 4'(DEPTH) || press_count !== 8'(DEPTH + 1) || key_ascii !== 8'h20) begin miscompares++;
         $display("FAIL full_push_pop: level=%0d press=%0d ascii=%h required %0d %0d 20",
                  fifo_level, press_count, key_ascii, DEPTH, DEPTH + 1); end
   endtask

   task automatic test_reset_capture();
      do_reset();
      for (int i = 0; i < 3; i++) send_byte(8'h1C);
      send_byte(8'h12);
      send_byte(8'h32);
      @(negedge clk);
      clrn = 1'b0;
      @(negedge clk);
      vectors++;
      if (fifo_level !== 4'd0 || key_valid !== 1'b0 || press_count !== 8'd0 || lut_scan !== 8'd0 ||
          shift_held !== 1'b0 || overflow !== 1'b0 || code_ready !== 1'b1) begin miscompares++;
         $display("FAIL reset_capture: level=%0d valid=%0b press=%0d scan=%h shift=%0b ovf=%0b rdy=%0b required 0 0 0 00 0 0 1",
                  fifo_level, key_valid, press_count, lut_scan, shift_held, overflow, code_ready); end
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (fifo_level !== 4'd0 || press_count !== 8'd0) begin miscompares++;
         $display("FAIL reset_no_push: level=%0d press=%0d required 0 0", fifo_level, press_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_shift();
      test_caps();
      test_extended();
      test_overflow();
      test_reset_capture();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequencing controller between the PS/2 receiver and the scan-code lookup table. It accepts raw scan-code bytes and decodes the F0 (break) and E0 (extended) prefixes. It tracks modifier and Caps Lock state, drives the registered lookup table's address port and applies case to its ASCII result. Resulting characters are queued in a small show-ahead FIFO for the display/consumer side.

## Interface
- FIFO_DEPTH, 8, character queue depth; power of two, ≥2
- clk  in  1  system clock, all logic on posedge
- clrn  in  1  synchronous active-low reset
- code_valid  in  1  raw scan byte present
- code  in  8  raw scan byte
- code_ready  out  1  controller can accept a byte (1 in IDLE, BRK, EXT, EXT_BRK)
- lut_scan  out  8  registered address to lookup table
- lut_ascii  in  8  lookup data; registered in table, valid one clk after lut_scan changes
- key_valid  out  1  FIFO non-empty
- key_ascii  out  8  head-of-FIFO character
- key_ready  in  1  consumer pops head when key_valid & key_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- press_count  out  8  characters queued since reset, wraps 255→0
- shift_held, ctrl_held, alt_held, caps_on  out  1 each  modifier status
- overflow  out  1  sticky: character dropped on full FIFO

## Operation
- Byte accepted on edge where code_valid & code_ready; otherwise ignored.
- States: IDLE, BRK, EXT, EXT_BRK, LOOKUP, CAPTURE.
- IDLE: F0→BRK; E0→EXT; 12/59→shift_held=1; 14→ctrl_held=1; 11→alt_held=1; 58→toggle caps_on only if caps key not already held, set caps_held; any other byte→lut_scan<=code, →LOOKUP.
- BRK: byte = released key. 12/59 clear shift_held. 14 clears ctrl_held. 11 clears alt_held. 58 clears caps_held. Then →IDLE. Nothing emitted.
- EXT: F0→EXT_BRK; 14→ctrl_held=1; 11→alt_held=1; any other byte dropped; →IDLE.
- EXT_BRK: 14/11 clear ctrl_held/alt_held; →IDLE.
- LOOKUP: wait one cycle, →CAPTURE.
- CAPTURE: lut_ascii sampled at this edge.
  - Value 0 (unmapped): dropped.
  - Value in 65..90 with (shift_held XOR caps_on)=0: add 32.
  - Otherwise pushed unchanged.
  - Successful push increments press_count.
  - →IDLE.
- Typematic repeats (same make byte without break) are emitted each time; caps_on does not re-toggle.
- FIFO: show-ahead; key_ascii = head while key_valid.
  - Push when full without simultaneous pop: drop, set overflow; press_count unchanged.
  - Push and pop same edge when full: both occur; no overflow; level unchanged.
  - Pop when empty: no effect.
- Modifier bytes never enter the FIFO.

## Timing
- Reset (clrn=0 at posedge): state IDLE; lut_scan=0; FIFO empty; key_valid=0; fifo_level=0; press_count=0; all held flags, caps_on and overflow 0; in-flight lookup discarded.
- clrn takes priority over every other event.
- Accept at edge E0 → LOOKUP. Edge E1: table registers ascii → CAPTURE. Edge E2: push. key_valid=1 in cycle after E2 if FIFO was empty.
- code_ready=0 during LOOKUP and CAPTURE (2 cycles). Prefix bytes complete in 1 cycle.
- Pop visible next cycle: fifo_level decrements, key_ascii advances.
- Flags update on the accept edge; case applied in CAPTURE uses flags current at E2.

## Test plan
- Reset, then byte 1C with no modifiers → after 3 edges key_valid=1, key_ascii=0x61, press_count=1, fifo_level=1; pop → key_valid=0.
- Bytes 12, 1C, F0 12, 1C → queue 0x41 then 0x61; shift_held 1 then 0.
- 58, F0 58, 58 (held), 58, F0 58, 32 → caps_on toggles once per press (ends 0). Caps-held repeat does not toggle. Final char 0x62.
- E0 14 → ctrl_held=1, no character; E0 F0 14 → ctrl_held=0; byte 77 (unmapped) → nothing queued.
- key_ready=0, send FIFO_DEPTH+1 presses of 29 → fifo_level=FIFO_DEPTH, overflow=1, press_count=FIFO_DEPTH. Then full-FIFO push with key_ready=1 on same edge → no drop, level unchanged.
- clrn=0 during CAPTURE with 3 entries queued → next cycle all outputs at reset values, no push.
